// File: rtl/fetch_unit_if.sv
// fetch_unit_if: branch redirect, icache request/response and decode handshake bundle.
interface fetch_unit_if;
    logic        branch_request_i;
    logic [31:0] branch_pc_i;
    logic        icache_rd_o;
    logic [31:0] icache_pc_o;
    logic        icache_accept_i;
    logic        icache_valid_i;
    logic        icache_error_i;
    logic [31:0] icache_inst_i;
    logic        fetch_valid_o;
    logic [31:0] fetch_instr_o;
    logic [31:0] fetch_pc_o;
    logic        fetch_fault_o;
    logic        fetch_accept_i;
    modport slave (
        input  branch_request_i, branch_pc_i, icache_accept_i, icache_valid_i,
               icache_error_i, icache_inst_i, fetch_accept_i,
        output icache_rd_o, icache_pc_o, fetch_valid_o, fetch_instr_o, fetch_pc_o, fetch_fault_o
    );
    modport master (
        output branch_request_i, branch_pc_i, icache_accept_i, icache_valid_i,
               icache_error_i, icache_inst_i, fetch_accept_i,
        input  icache_rd_o, icache_pc_o, fetch_valid_o, fetch_instr_o, fetch_pc_o, fetch_fault_o
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher with a 2-entry decode buffer,
// branch redirect/flush and halt-on-fault.
module fetch_unit #(
    parameter logic [31:0] BOOT_VECTOR = 32'h8000_0000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    fetch_unit_if.slave  bus
);
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic [31:0] r_fifo_pc    [2];
    logic [31:0] r_fifo_instr [2];
    logic [1:0]  r_fifo_fault;
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;
    logic        r_outstanding;
    logic        r_drop;
    logic        r_halt;

    logic w_issue;
    logic w_fire;
    logic w_resp;
    logic w_push;
    logic w_pop;

    // rst_i gates the request so nothing is issued while reset is held
    assign w_issue = rst_i && !r_outstanding && r_count != 2'd2 && !r_halt && !bus.branch_request_i;
    assign w_fire  = w_issue && bus.icache_accept_i;
    assign w_resp  = r_outstanding && bus.icache_valid_i;
    assign w_push  = w_resp && !r_drop && !bus.branch_request_i;
    assign w_pop   = r_count != 2'd0 && bus.fetch_accept_i && !bus.branch_request_i;

    assign bus.icache_rd_o   = w_issue;
    assign bus.icache_pc_o   = r_pc;
    assign bus.fetch_valid_o = r_count != 2'd0;
    assign bus.fetch_instr_o = r_fifo_instr[r_rd_ptr];
    assign bus.fetch_pc_o    = r_fifo_pc[r_rd_ptr];
    assign bus.fetch_fault_o = r_fifo_fault[r_rd_ptr];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pc            <= BOOT_VECTOR;
            r_req_pc        <= '0;
            r_fifo_pc[0]    <= '0;
            r_fifo_pc[1]    <= '0;
            r_fifo_instr[0] <= '0;
            r_fifo_instr[1] <= '0;
            r_fifo_fault    <= '0;
            r_rd_ptr        <= 1'b0;
            r_wr_ptr        <= 1'b0;
            r_count         <= '0;
            r_outstanding   <= 1'b0;
            r_drop          <= 1'b0;
            r_halt          <= 1'b0;
        end else begin
            if (w_fire) begin
                r_outstanding <= 1'b1;
                r_req_pc      <= r_pc;
            end else if (w_resp) begin
                r_outstanding <= 1'b0;
            end
            if (bus.branch_request_i) begin
                r_pc     <= {bus.branch_pc_i[31:2], 2'b00};
                r_count  <= '0;
                r_rd_ptr <= 1'b0;
                r_wr_ptr <= 1'b0;
                r_halt   <= 1'b0;
                // a response landing in the branch cycle is already discarded here
                r_drop   <= r_outstanding && !bus.icache_valid_i;
            end else begin
                if (w_fire)
                    r_pc <= r_pc + 32'd4;
                if (w_resp)
                    r_drop <= 1'b0;
                if (w_push) begin
                    r_fifo_pc[r_wr_ptr]    <= r_req_pc;
                    r_fifo_instr[r_wr_ptr] <= bus.icache_error_i ? 32'd0 : bus.icache_inst_i;
                    r_fifo_fault[r_wr_ptr] <= bus.icache_error_i;
                    r_wr_ptr               <= ~r_wr_ptr;
                    if (bus.icache_error_i)
                        r_halt <= 1'b1;
                end
                if (w_pop)
                    r_rd_ptr <= ~r_rd_ptr;
                r_count <= r_count + 2'(w_push) - 2'(w_pop);
            end
        end
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 BOOT_VECTOR, 32'h80000000, PC fetched first after reset.
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_i  in  1  asynchronous, active-low reset.
REQ-004 branch_request_i  in  1  redirect fetch; exception, branch or jump.
REQ-005 branch_pc_i  in  32  redirect target; bits [1:0] ignored.
REQ-006 icache_rd_o  out  1  fetch request valid.
REQ-007 icache_pc_o  out  32  fetch address, word aligned.
REQ-008 icache_accept_i  in  1  request accepted this cycle.
REQ-009 icache_valid_i  in  1  response valid.
REQ-010 icache_error_i  in  1  response carries bus/access fault; qualified by icache_valid_i.
REQ-011 icache_inst_i  in  32  fetched instruction word.
REQ-012 fetch_valid_o  out  1  instruction available to decode; drives decoder valid input.
REQ-013 fetch_instr_o  out  32  instruction word; drives decoder opcode input.
REQ-014 fetch_pc_o  out  32  PC of fetch_instr_o.
REQ-015 fetch_fault_o  out  1  fetch fault flag; drives decoder fetch_fault input.
REQ-016 fetch_accept_i  in  1  decode consumes head entry.

Function
REQ-017 The block SHALL hold a fetch PC register, a 2-entry FIFO of {pc, instr, fault}, an occupancy count (0..2), an outstanding flag, a drop flag and a halt flag.
REQ-018 icache_rd_o SHALL equal !outstanding && count<2 && !halt && !branch_request_i; icache_pc_o SHALL equal the fetch PC.
REQ-019 While icache_rd_o=1 and icache_accept_i=0, icache_pc_o SHALL stay stable.
REQ-020 On icache_rd_o && icache_accept_i: outstanding<=1 and PC<=PC+4, modulo 2^32 (32'hFFFFFFFC wraps to 0).
REQ-021 At most one request SHALL be outstanding; the response cycle clears outstanding, and the next request is issued no earlier than the following cycle.
REQ-022 A response with drop=0 SHALL push {request PC, icache_inst_i, icache_error_i} into the FIFO; a response with drop=1 SHALL be discarded, and it clears drop.
REQ-023 The FIFO SHALL never overflow (guaranteed by REQ-018); push and pop in the same cycle leave count unchanged.
REQ-024 fetch_valid_o SHALL equal (count!=0); fetch_instr_o, fetch_pc_o and fetch_fault_o SHALL present the head entry.
REQ-025 A pop occurs when fetch_valid_o && fetch_accept_i; head outputs SHALL remain stable while fetch_valid_o=1 and fetch_accept_i=0.
REQ-026 Latency: a response in cycle N SHALL appear on fetch_valid_o in cycle N+1 when the FIFO was empty.
REQ-027 A pushed faulting entry SHALL force fetch_instr_o=0 for that entry and set halt; no new requests are issued while halt=1.
REQ-028 branch_request_i SHALL, in the same edge:
- set PC<={branch_pc_i[31:2],2'b00}
- flush the FIFO (count<=0)
- clear halt
- set drop<=outstanding, so any in-flight response (including one arriving that cycle) is discarded.
REQ-029 Branch takes priority over simultaneous pop, push and request acceptance; icache_rd_o is 0 in the branch cycle.

Reset
REQ-030 While rst_i=0:
- PC=BOOT_VECTOR
- count=0; outstanding, drop and halt all 0
- FIFO contents 0
- icache_rd_o=0, fetch_valid_o=0, fetch_instr_o=0, fetch_pc_o=0, fetch_fault_o=0
REQ-031 Reset asserted mid-request SHALL abandon the request; a late response after reset release with outstanding=0 SHALL be ignored.
REQ-032 In the first cycle after rst_i rises, icache_rd_o SHALL be 1 with icache_pc_o=BOOT_VECTOR.

Verification
REQ-033 Reset release, icache always accepts, 1-cycle response, fetch_accept_i=1 -> fetch_pc_o sequence 0x80000000, 0x80000004, 0x80000008; each instruction is valid one cycle after its response.
REQ-034 fetch_accept_i=0 held -> exactly two entries buffered; icache_rd_o stays 0; head stays 0x80000000 until accept.
REQ-035 branch_request_i=1, branch_pc_i=0x00001003, while a request is outstanding -> the in-flight response is dropped and the next fetch_pc_o is 0x00001000.
REQ-036 Response with icache_error_i=1 at PC 0x80000004 -> fetch_fault_o=1 and fetch_instr_o=0 at that PC; no further icache_rd_o until branch; branch to 0x100 resumes fetch.
REQ-037 Branch to 0xFFFFFFFC -> fetched PCs are 0xFFFFFFFC, then 0x00000000.
REQ-038 rst_i=0 asserted with the FIFO full and a request outstanding -> all outputs 0 immediately; the response arriving after release is ignored; the first fetch is at BOOT_VECTOR.
